// File: rtl/nes_pkg.sv
// Shared definitions for the NES/SNES game-pad reader.
// Holds the reader FSM state type, the button bit positions within the
// button word, and the default half serial-clock period.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } nes_state_e;

    // Bit positions in the active-high button word; wire order is A first.
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // 6 us at 25.175 MHz.
    localparam int unsigned HALF_PERIOD_DEFAULT = 151;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk    - destination clock
//   rst_n  - synchronous active-low reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronised output (two cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// NES/SNES serial game-pad reader. On each start request it latches the pad,
// clocks out eight bits and publishes a frame-stable active-high button word
// with a one-cycle valid strobe.
// Ports:
//   clk         - system/pixel clock
//   rst_n       - synchronous active-low reset
//   start_i     - one-cycle read request, honoured only when idle
//   nes_data_i  - serial pad data, active-low, asynchronous
//   nes_latch_o - registered latch pulse to the pad
//   nes_clk_o   - registered shift clock to the pad
//   buttons_o   - {right,left,down,up,start,select,b,a}, active-high
//   valid_o     - one-cycle pulse when buttons_o has just been updated
//   busy_o      - high while a read is in progress
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       nes_data_i,
    output logic       nes_latch_o,
    output logic       nes_clk_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(2 * HALF_PERIOD);
    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF_PERIOD - 1);

    nes_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      buttons_q, buttons_d;
    logic            latch_q, latch_d;
    logic            nclk_q, nclk_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            sd;

    // Idle line is high (pull-up), so reset the synchroniser to 1.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (nes_data_i),
        .q_o   (sd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = LATCH;
                    idx_d   = 3'd0;
                end
            end
            LATCH: begin
                if (cnt_q == LatchLast) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                // Sample at the end of the low phase: data has settled for H cycles.
                if (cnt_q == HalfLast) begin
                    sh_d[idx_q] = ~sd;
                    state_d     = HIGH;
                    cnt_d       = '0;
                end
            end
            HIGH: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        latch_d   = (state_d == LATCH);
        nclk_d    = (state_d == HIGH);
        valid_d   = (state_d == DONE);
        busy_d    = (state_d == LATCH) || (state_d == LOW) || (state_d == HIGH);
        buttons_d = (state_d == DONE) ? sh_q : buttons_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            sh_q      <= 8'h00;
            buttons_q <= 8'h00;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            nclk_q    <= nclk_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign nes_latch_o = latch_q;
    assign nes_clk_o   = nclk_q;
    assign buttons_o   = buttons_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;

    localparam int H = 4;

    typedef struct {
        logic [7:0] pad;
        bit         unplugged;
        bit         overlap;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       nes_data;
    logic       nes_latch_o;
    logic       nes_clk_o;
    logic [7:0] buttons_o;
    logic       valid_o;
    logic       busy_o;

    int passed = 0;
    int total  = 0;

    // Pad model state
    logic [7:0] pad_bits  = 8'h00;
    bit         unplugged = 1'b0;
    int         pad_pos   = 0;

    // Monitor counters
    int  latch_cycles = 0;
    int  clk_rises    = 0;
    int  hi_run       = 0;
    int  bad_high     = 0;
    int  valid_cnt    = 0;
    bit  clk_prev     = 1'b0;

    logic [7:0] prev_exp = 8'h00;
    vec_t       vecs[6];

    nes_controller_reader #(
        .HALF_PERIOD (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .nes_data_i  (nes_data),
        .nes_latch_o (nes_latch_o),
        .nes_clk_o   (nes_clk_o),
        .buttons_o   (buttons_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-register pad: latch presents A, each nes_clk rise advances one bit.
    always @(posedge nes_latch_o) pad_pos = 0;
    always @(posedge nes_clk_o) pad_pos = pad_pos + 1;
    assign nes_data = unplugged ? 1'b1 :
                      (pad_pos < 8 ? ~pad_bits[pad_pos[2:0]] : 1'b1);

    always @(negedge clk) begin
        if (rst_n) begin
            if (nes_latch_o) latch_cycles = latch_cycles + 1;
            if (nes_clk_o && !clk_prev) begin
                clk_rises = clk_rises + 1;
                hi_run    = 1;
            end else if (nes_clk_o) begin
                hi_run = hi_run + 1;
            end
            if (!nes_clk_o && clk_prev && hi_run != H) bad_high = bad_high + 1;
            if (valid_o) valid_cnt = valid_cnt + 1;
        end
        clk_prev = nes_clk_o;
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic clear_mon();
        latch_cycles = 0;
        clk_rises    = 0;
        bad_high     = 0;
        valid_cnt    = 0;
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        int hold_bad;
        pad_bits  = v.pad;
        unplugged = v.unplugged;
        @(posedge clk);
        #1 clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("latch_at_t1", int'(nes_latch_o), 1);
        chk("busy_at_t1", int'(busy_o), 1);
        n        = 1;
        hold_bad = 0;
        while (!valid_o && n < 200) begin
            if (buttons_o != prev_exp) hold_bad++;
            if (v.overlap && (n == 10 || n == 40)) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("valid_cycle", n, 18 * H + 1);
        chk("buttons", int'(buttons_o), int'(v.exp));
        chk("busy_at_valid", int'(busy_o), 0);
        chk("hold_before_valid", hold_bad, 0);
        // Start during the DONE cycle must be ignored.
        if (v.overlap) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("latch_cycles", latch_cycles, 2 * H);
        chk("clk_pulses", clk_rises, 8);
        chk("clk_high_len_errs", bad_high, 0);
        chk("valid_pulses", valid_cnt, 1);
        chk("busy_after", int'(busy_o), 0);
        chk("buttons_held", int'(buttons_o), int'(v.exp));
        prev_exp = v.exp;
    endtask

    initial begin
        int   n;
        vec_t v;

        vecs[0] = '{pad: 8'h81, unplugged: 1'b0, overlap: 1'b0, exp: 8'h81};
        vecs[1] = '{pad: 8'h7E, unplugged: 1'b1, overlap: 1'b0, exp: 8'h00};
        vecs[2] = '{pad: 8'h5A, unplugged: 1'b0, overlap: 1'b1, exp: 8'h5A};
        vecs[3] = '{pad: 8'hFF, unplugged: 1'b0, overlap: 1'b0, exp: 8'hFF};
        vecs[4] = '{pad: 8'h10, unplugged: 1'b0, overlap: 1'b0, exp: 8'h10};
        vecs[5] = '{pad: 8'h0C, unplugged: 1'b0, overlap: 1'b0, exp: 8'h0C};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_latch", int'(nes_latch_o), 0);
        chk("rst_clk", int'(nes_clk_o), 0);
        chk("rst_buttons", int'(buttons_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset during the 4th nes_clk high phase.
        pad_bits  = 8'h3C;
        unplugged = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #1 clear_mon();
        n = 0;
        @(negedge clk);
        while (!(clk_rises == 4 && nes_clk_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_reach", int'(n < 200), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_latch", int'(nes_latch_o), 0);
        chk("midrst_clk", int'(nes_clk_o), 0);
        chk("midrst_buttons", int'(buttons_o), 0);
        chk("midrst_valid", int'(valid_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        rst_n    = 1'b1;
        prev_exp = 8'h00;
        v = '{pad: 8'h81, unplugged: 1'b0, overlap: 1'b0, exp: 8'h81};
        run_frame(v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Upstream input stage that drives the NES/SNES-style serial game-pad protocol and shifts in the 8 button bits once per video frame. It sits between the `NES_Latch`/`NES_Clk`/`NES_Data` pins and the player-control path. It presents a registered, active-high, frame-stable button word, plus a one-cycle `valid` strobe, to the input controller and player logic.

## Interface
- `HALF_PERIOD`, default 151: cycles per half serial-clock period (6 µs at 25.175 MHz); minimum 4.
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `start`  in  1  one-cycle request; connected to `frame_end`.
- `nes_data`  in  1  serial data from pad; active-low, asynchronous, externally pulled up.
- `nes_latch`  out  1  latch pulse to pad; registered.
- `nes_clk`  out  1  shift clock to pad; registered.
- `buttons`  out  8  active-high button state `{right,left,down,up,start,select,b,a}`; bit 0 is `a`.
- `valid`  out  1  one-cycle pulse when `buttons` has just been updated.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `valid` is asserted.

## Operation
- `nes_data` passes through a 2-flop synchroniser. All sampling uses the synchronised bit (`sd`).
- FSM states and transitions:
  - IDLE: `start` moves to LATCH. The phase counter `cnt` clears and bit index `idx` is set to 0.
  - LATCH: `nes_latch`=1 for 2·HALF_PERIOD cycles, then moves to LOW.
  - LOW: `nes_clk`=0 for HALF_PERIOD cycles. On the last cycle, `sh[idx] <= ~sd`, then moves to HIGH.
  - HIGH: `nes_clk`=1 for HALF_PERIOD cycles. On the last cycle, if `idx`==7 move to DONE; otherwise `idx++` and move to LOW.
  - DONE: `buttons <= sh` and `valid`=1, both for one cycle, then return to IDLE.
- The frame has 8 `nes_clk` pulses. The 8th pulse only clocks out the pad's trailing bit, which is ignored.
- Bit order on the wire is A, B, Select, Start, Up, Down, Left, Right, which maps to `sh[0..7]`.
- `buttons` changes only in DONE and holds between frames. A disconnected pad reads as all ones, so `buttons` becomes 8'h00.
- `start` is honoured only in IDLE. It is ignored in every other state, including DONE, and is not queued.
- `cnt` width is `$clog2(2*HALF_PERIOD)` and it is unsigned. `cnt` resets to 0 on every state change. There is no wrap beyond the terminal count.
- `idx` is 3 bits and saturates at 7, with no wrap.
- Reset values: `nes_latch`=0, `nes_clk`=0, `buttons`=8'h00, `valid`=0, `busy`=0, state IDLE, `sh`=0, synchroniser flops=1. Reset is honoured mid-frame, taking priority over every transition.

## Timing
- `start` high at edge *t* (in IDLE): at *t*+1, `nes_latch`=1 and `busy`=1.
- `nes_latch` is high for exactly 2·H cycles. The first `nes_clk` rising edge is H cycles after `nes_latch` falls.
- Each `nes_clk` pulse is high for H cycles and low for H cycles. There are exactly 8 rising edges.
- `valid` asserts at cycle *t*+18·H+1 after the `start` edge, with `buttons` updated on the same edge. `busy` drops on that same edge. IDLE is re-entered on the following cycle.
- Sampling occurs H cycles after each data transition, which far exceeds the 2-cycle synchroniser latency. The pad has ~H−2 cycles of settling margin.
- At H=151 a frame is 2719 cycles, well under one 420 000-cycle video frame, so no overrun is possible at the nominal rate.

## Structure
- Shared package `nes_pkg`:
  - state enum `{IDLE, LATCH, LOW, HIGH, DONE}`;
  - button index constants `BTN_A=0 … BTN_RIGHT=7`;
  - default `HALF_PERIOD`.
- One sub-module `sync_2ff`, a generic 2-flop synchroniser with a reset-value parameter, instantiated for `nes_data`.
- The remainder is a single FSM with `cnt`/`idx` counters. The target is ~150 lines of RTL.

## Test plan
- **Reset.** Hold `rst_n`=0 for 5 cycles. Require `nes_latch`=0, `nes_clk`=0, `buttons`=00, `valid`=0, `busy`=0.
- **Single frame, HALF_PERIOD=4.** A pad model drives A and Right pressed (wire sequence 0,1,1,1,1,1,1,0). Require:
  - `nes_latch` high for exactly 8 cycles;
  - exactly 8 `nes_clk` pulses, each high for 4 cycles;
  - `valid` at *t*+73;
  - `buttons`=8'h81.
- **Unplugged.** Hold `nes_data`=1 and pulse `start`. Require `buttons`=8'h00 with one `valid`.
- **Overlapping start.** Pulse `start` again at cycles +10, +40 and the DONE cycle. Require a single `valid`, 8 `nes_clk` pulses, and no restart of the latch.
- **Reset mid-frame.** Assert `rst_n`=0 during the 4th `nes_clk` high phase. Require all outputs reset on the next edge and `buttons`=00. A subsequent `start` must produce a clean full frame with correct data.
- **Hold between frames.** Run frame 1 with pattern 8'h10 and frame 2 with 8'h0C. Require `buttons`=8'h10 stable until frame 2's `valid` edge, then 8'h0C.
